ram_responder: RTL and testbench

RAM_RESPONDER -- requirements
Module: ram_responder

---
 rtl/ram_resp_pkg.sv | 25 ++
 rtl/ram_array.sv | 29 ++
 rtl/ram_responder.sv | 108 ++++++++++
 tb/tb_ram_responder.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_resp_pkg.sv
// Shared definitions for the RAM responder slice.
// Contents: bus widths, parameter defaults, legal latency bounds, the FSM
// state type, and a helper that sizes the internal word index.
package ram_resp_pkg;

  localparam int unsigned ADDR_W      = 16;
  localparam int unsigned DATA_W      = 16;
  localparam int unsigned LD_ADDR_W   = 8;
  localparam int unsigned DEPTH_DEF   = 256;
  localparam int unsigned LATENCY_DEF = 2;
  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;
  localparam int unsigned CNT_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic int unsigned addr_bits(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Instruction/data word storage: DEPTH x DW, no reset.
// Ports:
//   clk                       clock
//   wr_en, wr_addr, wr_data   synchronous write port
//   rd_en, rd_addr            synchronous read request
//   rd_data                   registered read data, held while rd_en=0
// A read and a write to the same word on one edge return the old word.
module ram_array #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8,
  parameter int unsigned DW    = 16
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/ram_responder.sv
// Latency-emulating read responder in front of a program-loadable word array.
// Ports:
//   clk, rst (async, active-low)
//   en_ram_in, addr     read request strobe and word address
//   en_ram_out, ins     one-cycle response strobe and held read data
//   ld_en/ld_addr/ld_data  program-load write port (any state)
//   busy                high while a request is waiting out its latency
//   err, err_clr        sticky out-of-range flag and its synchronous clear
// LATENCY outside 1..15 is clamped into that range.
module ram_responder
  import ram_resp_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned LATENCY = LATENCY_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_ram_in,
  input  logic [ADDR_W-1:0]    addr,
  output logic                 en_ram_out,
  output logic [DATA_W-1:0]    ins,
  input  logic                 ld_en,
  input  logic [LD_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]    ld_data,
  output logic                 busy,
  output logic                 err,
  input  logic                 err_clr
);

  localparam int unsigned AW = addr_bits(DEPTH);
  localparam int unsigned LAT_EFF =
    (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
    (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 1);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   cap_addr;
  logic                en_out_q, err_q, ins_ok;
  logic                accept, fire, cap_ok, ld_ok, rd_en;
  logic [DATA_W-1:0]   rd_data;

  assign cap_ok = 32'(cap_addr) < DEPTH;
  assign ld_ok  = ld_en && (32'(ld_addr) < DEPTH);

  ram_array #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DATA_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (ld_ok),
    .wr_addr (AW'(ld_addr)),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (AW'(cap_addr)),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (en_ram_in) state_nx = ST_WAIT;
      ST_WAIT: if (cnt == '0) state_nx = ST_RESP;
      ST_RESP: state_nx = en_ram_in ? ST_WAIT : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    accept     = en_ram_in && (state == ST_IDLE || state == ST_RESP);
    fire       = (state == ST_WAIT) && (cnt == '0);
    rd_en      = fire && cap_ok;
    busy       = (state == ST_WAIT);
    en_ram_out = en_out_q;
    err        = err_q;
    // The array's read register cannot be reset, so a flag set only by an
    // in-range response decides whether its word or zero is presented.
    ins        = ins_ok ? rd_data : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt      <= '0;
      cap_addr <= '0;
      en_out_q <= 1'b0;
      ins_ok   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      en_out_q <= fire;
      if (accept) begin
        cap_addr <= addr;
        cnt      <= CNT_LOAD;
      end else if (state == ST_WAIT && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (fire) ins_ok <= cap_ok;
      // A new error wins over a simultaneous clear.
      err_q <= (fire && !cap_ok) || (err_q && !err_clr);
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
module tb_ram_responder;

  localparam int unsigned DEPTH = 256;
  localparam int unsigned LAT   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en_ram_in = 1'b0;
  logic [15:0] addr = '0;
  logic        en_ram_out;
  logic [15:0] ins;
  logic        ld_en = 1'b0;
  logic [7:0]  ld_addr = '0;
  logic [15:0] ld_data = '0;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  always #5 clk = ~clk;

  ram_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .en_ram_in(en_ram_in), .addr(addr),
    .en_ram_out(en_ram_out), .ins(ins), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .busy(busy), .err(err), .err_clr(err_clr)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a request accepted at edge t answers at edge t+LAT and
  // nothing new is accepted before edge t+LAT+1.
  int unsigned e = 0;
  bit          m_have = 0;
  int unsigned m_acc_edge = 0;
  logic [15:0] m_acc_addr = '0;
  logic [15:0] mem_m [256];
  logic        exp_out = 0, exp_busy = 0, exp_err = 0;
  logic [15:0] exp_ins = '0;

  task automatic model_reset();
    m_have = 0; exp_out = 0; exp_ins = '0; exp_busy = 0; exp_err = 0;
  endtask

  task automatic model_edge();
    bit bad;
    bad = 0;
    if (m_have && e == m_acc_edge + LAT) begin
      exp_out = 1;
      if (m_acc_addr < DEPTH) exp_ins = mem_m[m_acc_addr];
      else begin exp_ins = '0; bad = 1; end
    end else exp_out = 0;
    exp_err = bad || (exp_err && !err_clr);
    if (en_ram_in && (!m_have || e >= m_acc_edge + LAT + 1)) begin
      m_have = 1; m_acc_edge = e; m_acc_addr = addr;
    end
    exp_busy = m_have && (e < m_acc_edge + LAT);
    if (ld_en && ld_addr < DEPTH) mem_m[ld_addr] = ld_data;
  endtask

  task automatic step();
    @(posedge clk);
    e++;
    if (!rst) model_reset(); else model_edge();
    #1;
  endtask

  function automatic bit can_accept_next();
    return !m_have || (e + 1 >= m_acc_edge + LAT + 1);
  endfunction

  task automatic load(input logic [7:0] a, input logic [15:0] d);
    ld_en = 1; ld_addr = a; ld_data = d;
    step();
    ld_en = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    step(); step();
    n_checks++; if (en_ram_out !== 1'b0) begin n_fail++; $display("FAIL reset_en_ram_out: got %b expected 0", en_ram_out); end
    n_checks++; if (ins !== 16'h0000) begin n_fail++; $display("FAIL reset_ins: got %h expected 0000", ins); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1;
    for (int i = 0; i < 256; i++) load(8'(i), 16'($urandom));
    load(8'd0, 16'h1111); load(8'd1, 16'h2222); load(8'd2, 16'h3333);
    load(8'd5, 16'hA1B2); load(8'd7, 16'h0007);
  endtask

  task automatic test_single();
    int pulses, busys;
    logic [15:0] got;
    pulses = 0; busys = 0; got = '0;
    en_ram_in = 1; addr = 16'd5;
    step();
    en_ram_in = 0;
    if (busy) busys++;
    for (int c = 1; c <= 5; c++) begin
      step();
      n_checks++; if (en_ram_out !== exp_out) begin n_fail++; $display("FAIL single_out c%0d: got %b expected %b", c, en_ram_out, exp_out); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL single_busy c%0d: got %b expected %b", c, busy, exp_busy); end
      n_checks++; if (ins !== exp_ins) begin n_fail++; $display("FAIL single_ins c%0d: got %h expected %h", c, ins, exp_ins); end
      if (en_ram_out) begin
        pulses++; got = ins;
        n_checks++; if (c != LAT) begin n_fail++; $display("FAIL single_latency: got %0d expected %0d", c, LAT); end
      end
      if (busy) busys++;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL single_pulses: got %0d expected 1", pulses); end
    n_checks++; if (busys != LAT) begin n_fail++; $display("FAIL single_busy_cycles: got %0d expected %0d", busys, LAT); end
    n_checks++; if (got !== 16'hA1B2) begin n_fail++; $display("FAIL single_data: got %h expected a1b2", got); end
  endtask

  task automatic test_back_to_back();
    int idx, nresp;
    logic [15:0] rdata [3];
    int unsigned redge [3];
    idx = 0; nresp = 0;
    for (int c = 0; c < 12; c++) begin
      if (can_accept_next()) begin
        if (idx < 3) begin addr = 16'(idx); idx++; en_ram_in = 1; end
        else en_ram_in = 0;
      end else begin
        addr = 16'd9; en_ram_in = 1;
      end
      step();
      n_checks++; if (en_ram_out !== exp_out) begin n_fail++; $display("FAIL b2b_out c%0d: got %b expected %b", c, en_ram_out, exp_out); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b expected %b", c, busy, exp_busy); end
      if (en_ram_out) begin
        if (nresp < 3) begin rdata[nresp] = ins; redge[nresp] = e; end
        nresp++;
      end
    end
    en_ram_in = 0;
    n_checks++; if (nresp != 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", nresp); end
    if (nresp >= 3) begin
      n_checks++; if (rdata[0] !== 16'h1111) begin n_fail++; $display("FAIL b2b_d0: got %h expected 1111", rdata[0]); end
      n_checks++; if (rdata[1] !== 16'h2222) begin n_fail++; $display("FAIL b2b_d1: got %h expected 2222", rdata[1]); end
      n_checks++; if (rdata[2] !== 16'h3333) begin n_fail++; $display("FAIL b2b_d2: got %h expected 3333", rdata[2]); end
      n_checks++; if (redge[1] - redge[0] != LAT + 1) begin n_fail++; $display("FAIL b2b_gap01: got %0d expected %0d", redge[1] - redge[0], LAT + 1); end
      n_checks++; if (redge[2] - redge[1] != LAT + 1) begin n_fail++; $display("FAIL b2b_gap12: got %0d expected %0d", redge[2] - redge[1], LAT + 1); end
    end
    step();
  endtask

  task automatic test_err();
    bit seen;
    seen = 0;
    en_ram_in = 1; addr = 16'h0100;
    step();
    en_ram_in = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL err_flag c%0d: got %b expected %b", c, err, exp_err); end
      if (en_ram_out && !seen) begin
        seen = 1;
        n_checks++; if (ins !== 16'h0000) begin n_fail++; $display("FAIL err_ins: got %h expected 0000", ins); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set: got %b expected 1", err); end
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL err_resp: got none expected one response"); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_held: got %b expected 1", err); end
    err_clr = 1; step(); err_clr = 0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err); end
    en_ram_in = 1; addr = 16'hFFFF;
    step();
    en_ram_in = 0;
    for (int c = 0; c < LAT; c++) begin
      err_clr = (e + 1 == m_acc_edge + LAT);
      step();
    end
    err_clr = 0;
    n_checks++; if (en_ram_out !== 1'b1) begin n_fail++; $display("FAIL err2_out: got %b expected 1", en_ram_out); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_clr_collide: got %b expected 1", err); end
    err_clr = 1; step(); err_clr = 0;
  endtask

  task automatic test_read_before_write();
    en_ram_in = 1; addr = 16'd7;
    step();
    en_ram_in = 0;
    for (int c = 0; c < LAT; c++) begin
      if (e + 1 == m_acc_edge + LAT) begin ld_en = 1; ld_addr = 8'd7; ld_data = 16'hBEEF; end
      step();
      ld_en = 0;
    end
    n_checks++; if (en_ram_out !== 1'b1) begin n_fail++; $display("FAIL rbw_out: got %b expected 1", en_ram_out); end
    n_checks++; if (ins !== 16'h0007) begin n_fail++; $display("FAIL rbw_old: got %h expected 0007", ins); end
    step();
    en_ram_in = 1; addr = 16'd7;
    step();
    en_ram_in = 0;
    repeat (LAT) step();
    n_checks++; if (en_ram_out !== 1'b1) begin n_fail++; $display("FAIL rbw_out2: got %b expected 1", en_ram_out); end
    n_checks++; if (ins !== 16'hBEEF) begin n_fail++; $display("FAIL rbw_new: got %h expected beef", ins); end
    step();
  endtask

  task automatic test_reset_mid_wait();
    int pulses;
    logic [15:0] got;
    pulses = 0; got = '0;
    load(8'h20, 16'h5A5A);
    en_ram_in = 1; addr = 16'h0020;
    step();
    en_ram_in = 0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_pre: got %b expected 1", busy); end
    #2 rst = 0;
    #1 model_reset();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b expected 0", busy); end
    n_checks++; if (ins !== 16'h0000) begin n_fail++; $display("FAIL async_ins: got %h expected 0000", ins); end
    n_checks++; if (en_ram_out !== 1'b0) begin n_fail++; $display("FAIL async_out: got %b expected 0", en_ram_out); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL async_err: got %b expected 0", err); end
    step(); step();
    rst = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      n_checks++; if (en_ram_out !== 1'b0) begin n_fail++; $display("FAIL abort_out c%0d: got %b expected 0", c, en_ram_out); end
    end
    en_ram_in = 1; addr = 16'h0020;
    step();
    en_ram_in = 0;
    for (int c = 1; c <= 4; c++) begin
      step();
      n_checks++; if (en_ram_out !== exp_out) begin n_fail++; $display("FAIL post_rst_out c%0d: got %b expected %b", c, en_ram_out, exp_out); end
      if (en_ram_out) begin pulses++; got = ins; end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL post_rst_pulses: got %0d expected 1", pulses); end
    n_checks++; if (got !== 16'h5A5A) begin n_fail++; $display("FAIL post_rst_data: got %h expected 5a5a", got); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en_ram_in = 1'($urandom_range(0, 1));
      addr = ($urandom_range(0, 9) == 0) ? (16'($urandom) | 16'h0100) : 16'($urandom_range(0, 255));
      ld_en = ($urandom_range(0, 3) == 0);
      ld_addr = 8'($urandom);
      ld_data = 16'($urandom);
      err_clr = ($urandom_range(0, 7) == 0);
      step();
      n_checks++; if (en_ram_out !== exp_out) begin n_fail++; $display("FAIL rand_out c%0d: got %b expected %b", c, en_ram_out, exp_out); end
      n_checks++; if (ins !== exp_ins) begin n_fail++; $display("FAIL rand_ins c%0d: got %h expected %h", c, ins, exp_ins); end
      n_checks++; if (busy !== exp_busy) begin n_fail++; $display("FAIL rand_busy c%0d: got %b expected %b", c, busy, exp_busy); end
      n_checks++; if (err !== exp_err) begin n_fail++; $display("FAIL rand_err c%0d: got %b expected %b", c, err, exp_err); end
    end
    en_ram_in = 0; ld_en = 0; err_clr = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_err();
    test_read_before_write();
    test_reset_mid_wait();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
